// File: rtl/fetch_queue.sv
// Circular instruction/PC queue between fetch and decode, with flush and occupancy status.
// Latency: 1 cycle from push to head visibility; head is read straight from storage.
// Backpressure: ready_in drops when full or flushing; a same-cycle pop does not free a slot for a push.
module fetch_queue #(
   parameter int DEPTH        = 4,
   parameter int XLEN         = 32,
   parameter int AFULL_THRESH = DEPTH - 1
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic                       flush,
   input  logic                       valid_in,
   output logic                       ready_in,
   input  logic [XLEN-1:0]            instr_in,
   input  logic [XLEN-1:0]            pc_in,
   output logic                       valid_out,
   input  logic                       ready_out,
   output logic [XLEN-1:0]            instr_out,
   output logic [XLEN-1:0]            pc_out,
   output logic [$clog2(DEPTH+1)-1:0] count,
   output logic                       almost_full
);

   localparam int PW = $clog2(DEPTH);
   localparam int CW = $clog2(DEPTH + 1);
   localparam logic [CW-1:0] FULL_CNT  = CW'(DEPTH);
   localparam logic [CW-1:0] AFULL_CNT = CW'(AFULL_THRESH);

   typedef struct packed {
      logic [XLEN-1:0] instr;
      logic [XLEN-1:0] pc;
   } entry_t;

   entry_t          mem [DEPTH];
   logic [PW-1:0]   wr_ptr;
   logic [PW-1:0]   rd_ptr;
   logic [CW-1:0]   cnt;
   logic            push;
   logic            pop;

   // Handshake gating: nothing transfers during reset or flush, and a full queue refuses
   // pushes even if the head leaves this cycle.
   assign ready_in    = reset & (cnt != FULL_CNT) & ~flush;
   assign valid_out   = reset & (cnt != '0) & ~flush;
   assign push        = valid_in & ready_in;
   assign pop         = valid_out & ready_out;

   assign instr_out   = mem[rd_ptr].instr;
   assign pc_out      = mem[rd_ptr].pc;
   assign count       = cnt;
   assign almost_full = (cnt >= AFULL_CNT);

   // Pointer, occupancy and storage update; reset also wipes storage, flush only empties it.
   always_ff @(posedge clk) begin
      if (!reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         cnt    <= '0;
         for (int i = 0; i < DEPTH; i++) begin
            mem[i] <= '0;
         end
      end else if (flush) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         cnt    <= '0;
      end else begin
         if (push) begin
            mem[wr_ptr] <= '{instr: instr_in, pc: pc_in};
            wr_ptr      <= wr_ptr + PW'(1);
         end
         if (pop) begin
            rd_ptr <= rd_ptr + PW'(1);
         end
         case ({push, pop})
            2'b10:   cnt <= cnt + CW'(1);
            2'b01:   cnt <= cnt - CW'(1);
            default: cnt <= cnt;
         endcase
      end
   end

endmodule

// File: tb/tb_fetch_queue.sv
// Scoreboard bench for fetch_queue: directed test-plan sequences, then random traffic.
// Latency: inputs change on the falling edge and are checked 1-2 time units later.
// Backpressure: random ready_out, flush and reset, checked against a queue-based model.
module tb_fetch_queue;

   localparam int DEPTH = 4;
   localparam int XLEN  = 32;
   localparam int THR   = DEPTH - 1;

   logic            clk = 1'b0;
   logic            reset = 1'b0;
   logic            flush = 1'b0;
   logic            valid_in = 1'b0;
   logic            ready_in;
   logic [XLEN-1:0] instr_in = '0;
   logic [XLEN-1:0] pc_in = '0;
   logic            valid_out;
   logic            ready_out = 1'b0;
   logic [XLEN-1:0] instr_out;
   logic [XLEN-1:0] pc_out;
   logic [2:0]      count;
   logic            almost_full;

   // second instance for the small-depth / wide-word configuration
   logic            s_reset = 1'b0;
   logic            s_flush = 1'b0;
   logic            s_vin = 1'b0;
   logic            s_rdy;
   logic [63:0]     s_instr_in = '0;
   logic [63:0]     s_pc_in = '0;
   logic            s_vout;
   logic            s_rout = 1'b0;
   logic [63:0]     s_instr_out;
   logic [63:0]     s_pc_out;
   logic [1:0]      s_count;
   logic            s_af;

   int errors = 0;
   int checks = 0;
   bit done   = 1'b0;

   typedef struct {
      logic [XLEN-1:0] instr;
      logic [XLEN-1:0] pc;
   } item_t;

   item_t sb_q[$];
   int    mcount = 0;
   bit    was_reset = 1'b0;

   always #5 clk = ~clk;

   fetch_queue #(.DEPTH(DEPTH), .XLEN(XLEN), .AFULL_THRESH(THR)) dut (
      .clk(clk), .reset(reset), .flush(flush),
      .valid_in(valid_in), .ready_in(ready_in), .instr_in(instr_in), .pc_in(pc_in),
      .valid_out(valid_out), .ready_out(ready_out), .instr_out(instr_out), .pc_out(pc_out),
      .count(count), .almost_full(almost_full)
   );

   fetch_queue #(.DEPTH(2), .XLEN(64), .AFULL_THRESH(1)) dut_s (
      .clk(clk), .reset(s_reset), .flush(s_flush),
      .valid_in(s_vin), .ready_in(s_rdy), .instr_in(s_instr_in), .pc_in(s_pc_in),
      .valid_out(s_vout), .ready_out(s_rout), .instr_out(s_instr_out), .pc_out(s_pc_out),
      .count(s_count), .almost_full(s_af)
   );

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // One cycle of stimulus: drive, check status against the model, then advance the model.
   task automatic cyc(input bit v, input bit r, input bit f, input bit rs, input logic [XLEN-1:0] pc);
      bit exp_rdy, exp_vld, acc, deq;
      @(negedge clk);
      valid_in  = v;
      ready_out = r;
      flush     = f;
      reset     = rs;
      pc_in     = pc;
      instr_in  = $urandom;
      #1;
      exp_rdy = rs && !f && (mcount != DEPTH);
      exp_vld = rs && !f && (mcount != 0);
      chk("count", 64'(count), 64'(mcount));
      chk("ready_in", 64'(ready_in), 64'(exp_rdy));
      chk("valid_out", 64'(valid_out), 64'(exp_vld));
      chk("almost_full", 64'(almost_full), 64'(mcount >= THR));
      if (was_reset) begin
         chk("instr_out_after_reset", 64'(instr_out), 64'(0));
         chk("pc_out_after_reset", 64'(pc_out), 64'(0));
      end
      was_reset = !rs;
      if (!rs || f) begin
         mcount = 0;
         sb_q.delete();
      end else begin
         acc = v && exp_rdy;
         deq = exp_vld && r;
         if (acc) sb_q.push_back('{instr: instr_in, pc: pc_in});
         mcount = mcount + int'(acc) - int'(deq);
      end
   endtask

   // Monitor: whenever the head is presented it must match the oldest expected entry.
   initial begin
      item_t h;
      while (!done) begin
         @(negedge clk);
         #2;
         if (valid_out) begin
            if (sb_q.size() == 0) begin
               chk("head_unexpected", 64'(1), 64'(0));
            end else begin
               h = sb_q[0];
               chk("instr_out", 64'(instr_out), 64'(h.instr));
               chk("pc_out", 64'(pc_out), 64'(h.pc));
               if (ready_out) void'(sb_q.pop_front());
            end
         end
      end
   end

   initial begin
      // reset held, then released
      cyc(0, 0, 0, 0, 0);
      cyc(0, 0, 0, 0, 0);
      cyc(0, 0, 0, 1, 0);

      // fill to full with decode stalled, one refused push, then drain
      for (int i = 0; i < 4; i++) cyc(1, 0, 0, 1, 32'(i * 4));
      cyc(1, 0, 0, 1, 32'h10);
      for (int i = 0; i < 5; i++) cyc(0, 1, 0, 1, 0);

      // streaming: 12 back-to-back pushes with decode always ready
      for (int i = 0; i < 12; i++) cyc(1, 1, 0, 1, 32'h1000 + 32'(i * 4));
      cyc(0, 1, 0, 1, 0);

      // full with simultaneous pop: push refused, then accepted next cycle
      for (int i = 0; i < 4; i++) cyc(1, 0, 0, 1, 32'h2000 + 32'(i * 4));
      cyc(1, 1, 0, 1, 32'h2010);
      cyc(1, 0, 0, 1, 32'h2010);
      for (int i = 0; i < 5; i++) cyc(0, 1, 0, 1, 0);

      // flush mid-stream with a push offered in the flush cycle
      for (int i = 0; i < 3; i++) cyc(1, 0, 0, 1, 32'h3000 + 32'(i * 4));
      cyc(1, 0, 1, 1, 32'h100);
      cyc(1, 0, 0, 1, 32'h200);
      cyc(0, 1, 0, 1, 0);
      cyc(0, 1, 0, 1, 0);

      // reset mid-operation
      cyc(1, 0, 0, 1, 32'h400);
      cyc(1, 0, 0, 1, 32'h404);
      cyc(0, 0, 0, 0, 0);
      cyc(0, 0, 0, 1, 0);
      cyc(0, 1, 0, 1, 0);

      // random traffic
      for (int i = 0; i < 2000; i++) begin
         cyc(bit'($urandom_range(0, 3) != 0), bit'($urandom_range(0, 2) != 0),
             bit'($urandom_range(0, 39) == 0), bit'($urandom_range(0, 79) != 0), $urandom);
      end

      // drain and confirm nothing was left behind
      for (int i = 0; i < DEPTH + 2; i++) cyc(0, 1, 0, 1, 0);
      chk("drained", 64'(sb_q.size()), 64'(0));

      // DEPTH=2, XLEN=64, AFULL_THRESH=1
      @(negedge clk); s_reset = 1'b0;
      @(negedge clk); s_reset = 1'b1;
      #1;
      chk("s_count_reset", 64'(s_count), 64'(0));
      chk("s_af_reset", 64'(s_af), 64'(0));
      chk("s_ready_release", 64'(s_rdy), 64'(1));
      chk("s_vout_reset", 64'(s_vout), 64'(0));
      s_vin = 1'b1; s_pc_in = 64'hFFFF_FFFF_0000_0004; s_instr_in = 64'hDEAD_BEEF_CAFE_F00D;
      @(negedge clk);
      s_pc_in = 64'h0123_4567_89AB_CDEF; s_instr_in = 64'h1111_2222_3333_4444;
      #1;
      chk("s_count_1", 64'(s_count), 64'(1));
      chk("s_af_1", 64'(s_af), 64'(1));
      chk("s_vout_1", 64'(s_vout), 64'(1));
      chk("s_pc_wide", s_pc_out, 64'hFFFF_FFFF_0000_0004);
      chk("s_instr_wide", s_instr_out, 64'hDEAD_BEEF_CAFE_F00D);
      @(negedge clk);
      s_vin = 1'b0; s_rout = 1'b1;
      #1;
      chk("s_count_full", 64'(s_count), 64'(2));
      chk("s_ready_full", 64'(s_rdy), 64'(0));
      chk("s_pc_head_held", s_pc_out, 64'hFFFF_FFFF_0000_0004);
      @(negedge clk);
      s_rout = 1'b0;
      #1;
      chk("s_count_pop", 64'(s_count), 64'(1));
      chk("s_pc_second", s_pc_out, 64'h0123_4567_89AB_CDEF);
      chk("s_ready_after_pop", 64'(s_rdy), 64'(1));

      done = 1'b1;
      @(negedge clk);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
